mult_unit: RTL and testbench
============================

# mult_unit

Sequential 32x32 multiplier for MULT/MULTU, sitting in the execute stage beside the ALU.
- Performs radix-2 shift-and-add over 32 iterations using a 32-bit carry-lookahead add with carry-out, built from the team's CLA blocks.
- Writes a 64-bit product into HI/LO registers that later MFHI/MFLO stages read.
- Signed operation uses magnitude multiply followed by a conditional 64-bit two's-complement negate.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start.
- a  input  32  multiplicand; captured with start.
- b  input  32  multiplier; captured with start.
- busy  output  1  high while an operation is in RUN or FIX.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  32  product bits [63:32]; held until the next completion.
- lo  output  32  product bits [31:0]; held until the next completion.

## Operation
States:
- IDLE
  - start=1: capture mcand=|a|, mplier=|b|, where the magnitude is taken only if is_signed.
  - In the same edge: capture neg=is_signed&(a[31]^b[31]), set acc=0, count=0, and go to RUN.
  - start=0: stay in IDLE.
- RUN
  - Each cycle: sum[32:0] = acc[31:0] + (mplier[0] ? mcand : 0).
  - Then shift {sum[32:0], mplier[31:0]} right by 1 into {acc, mplier}.
  - count increments each cycle; after the iteration with count=31, go to FIX.
- FIX
  - prod = {acc, mplier}.
  - If neg, prod = ~prod + 1 (64-bit, wraps); otherwise unchanged.
  - Register hi=prod[63:32], lo=prod[31:0], done=1, and go to IDLE.

Rules:
- The magnitude of 0x80000000 is 0x80000000, interpreted as unsigned 2^31, so no overflow case exists.
- A negated zero stays zero.
- start while busy=1 is ignored: operands are not recaptured and no error is raised.
- start in the cycle done=1 is accepted, because the state is already IDLE.
- Inputs a, b and is_signed may change freely after the capture edge.
- hi/lo change only at the FIX edge. Partial products are never visible on hi/lo.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, and internal registers=0.
- Reset mid-operation aborts the operation: no done pulse, and hi/lo cleared to 0.
- rst has priority over start.

## Timing
- Edge E0 samples start=1 in IDLE.
- busy=1 from the cycle after E0 through the cycle after E32.
- Edges E1..E32 perform the 32 RUN iterations.
- Edge E33 is FIX: hi/lo valid and done=1 in the cycle after E33, and busy=0 in that same cycle.
- Fixed latency: 33 cycles from the start edge to done, identical for signed and unsigned.
- Back-to-back throughput: one result every 33 cycles.
- The adder critical path is one 32-bit CLA add per cycle. The FIX negate is a 64-bit increment and must meet timing in the same clock.

## Test plan
- Unsigned basic: MULTU a=3, b=5 -> done in the cycle after E33; hi=0x00000000, lo=0x0000000F; busy high for exactly 33 cycles.
- Unsigned max: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Also MULTU 0x80000000*2 -> hi=0x00000001, lo=0.
- Signed mixed and zero: MULT -1*1 -> hi=lo=0xFFFFFFFF. MULT -7*0 -> hi=lo=0. MULT -3*-4 -> hi=0, lo=0x0000000C.
- Signed extreme: MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0. MULT 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Handshake:
  - MULTU 6*7, then pulse start with a=9, b=9 at cycle 10 while busy -> result is still lo=42, with no second done.
  - start asserted in the done cycle with 2*2 -> a second done 33 cycles later with lo=4; hi/lo hold 42 in between.
- Reset:
  - After reset -> hi=lo=0, busy=done=0.
  - rst at cycle 15 of an operation -> busy=0 and hi/lo=0 the next cycle; no done pulse follows.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/mult_unit.sv
// mult_unit: sequential 32x32 multiplier for MULT/MULTU in the execute stage.
// Radix-2 shift-and-add over WIDTH iterations. Signed operands are converted
// to magnitudes at capture time, and the 2*WIDTH-bit product is negated in a
// final FIX cycle if the operand signs differed.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; wins over start
//   start      operation request, sampled only in IDLE
//   is_signed  1 = MULT (two's complement), 0 = MULTU; captured with start
//   a, b       multiplicand / multiplier; captured with start
//   busy       high while in RUN or FIX
//   done       one-cycle pulse when hi/lo update
//   hi, lo     product [2W-1:W] / [W-1:0]; held until the next completion
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; hi/lo hold the last product
// S_RUN  | one add-and-shift iteration per cycle, WIDTH cycles in total
// S_FIX  | conditional negate, hi/lo written, done pulsed
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic               neg;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend, sum;
  logic               sum_cout;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Magnitude of the most negative value is itself, read as unsigned.
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

  assign addend = mplier[0] ? mcand : '0;

  // acc + addend as a chain of 4-bit carry-lookahead groups.
  logic       c_grp;
  logic [3:0] g4, p4;
  logic       c1, c2, c3, c4;

  always_comb begin
    c_grp    = 1'b0;
    sum      = '0;
    g4       = '0;
    p4       = '0;
    c1       = 1'b0;
    c2       = 1'b0;
    c3       = 1'b0;
    c4       = 1'b0;
    for (int gi = 0; gi < WIDTH / 4; gi++) begin
      g4 = acc[4*gi +: 4] & addend[4*gi +: 4];
      p4 = acc[4*gi +: 4] ^ addend[4*gi +: 4];
      c1 = g4[0] | (p4[0] & c_grp);
      c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c_grp);
      c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
         | (p4[2] & p4[1] & p4[0] & c_grp);
      c4 = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & c_grp);
      sum[4*gi +: 4] = p4 ^ {c3, c2, c1, c_grp};
      c_grp = c4;
    end
    sum_cout = c_grp;
  end

  assign prod     = {acc, mplier};
  assign prod_fix = neg ? (~prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod;

  assign busy = (state == S_RUN) || (state == S_FIX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (count == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // count is a down-counter of remaining iterations; zero marks the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= CW'(WIDTH - 1);
          end
        end
        S_RUN: begin
          acc    <= {sum_cout, sum[WIDTH-1:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          count  <= count - 1'b1;
        end
        S_FIX: begin
          hi   <= prod_fix[2*WIDTH-1:WIDTH];
          lo   <= prod_fix[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  // Values hi/lo must show until the next completion.
  logic [31:0] hold_hi = '0;
  logic [31:0] hold_lo = '0;

  int lat, bcyc, ndone;
  bit hold_ok;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge, with
  // the operand inputs scrambled to show they are not re-sampled.
  task automatic start_op(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    start     = 1'b1;
    is_signed = sgn;
    a         = x;
    b         = y;
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~sgn;
    a         = ~x;
    b         = y ^ 32'h5A5A5A5A;
  endtask

  task automatic wait_done(output int lat_o, output int bcyc_o, output bit hold_o);
    lat_o  = 0;
    bcyc_o = 0;
    hold_o = 1'b1;
    while (!done && lat_o < 60) begin
      if (busy) bcyc_o++;
      if (hi !== hold_hi || lo !== hold_lo) hold_o = 1'b0;
      @(negedge clk);
      lat_o++;
    end
  endtask

  task automatic run_op(input string tag, input bit sgn, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    start_op(sgn, x, y);
    wait_done(lat, bcyc, hold_ok);
    check({tag, "_latency"}, lat, 33);
    check({tag, "_busy_cycles"}, bcyc, 33);
    check({tag, "_hold"}, hold_ok, 1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_busy_at_done"}, busy, 0);
    hold_hi = eh;
    hold_lo = el;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // rst has priority over start
    start = 1'b1;
    a     = 32'd3;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("rst_prio_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_prio_idle", busy, 0);

    run_op("u_3x5",      1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F);
    run_op("u_max",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("u_msb_x2",   1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000);
    run_op("u_ff_x1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF);
    run_op("u_shift16",  1'b0, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780);
    run_op("s_m1x1",     1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("s_m7x0",     1'b1, 32'hFFFFFFF9, 32'd0,        32'h00000000, 32'h00000000);
    run_op("s_m3xm4",    1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C);
    run_op("s_5xm3",     1'b1, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("s_min_sq",   1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("s_min_x1",   1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000);

    // start while busy is ignored
    start_op(1'b0, 32'd6, 32'd7);
    repeat (8) @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcyc, hold_ok);
    check("busy_start_latency", lat, 24);
    check("busy_start_hold", hold_ok, 1);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 42);
    hold_hi = 32'd0;
    hold_lo = 32'd42;

    // start in the done cycle is accepted
    start     = 1'b1;
    is_signed = 1'b0;
    a         = 32'd2;
    b         = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_single", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(lat, bcyc, hold_ok);
    check("b2b_latency", lat, 33);
    check("b2b_hold42", hold_ok, 1);
    check("b2b_hi", hi, 0);
    check("b2b_lo", lo, 4);
    hold_hi = 32'd0;
    hold_lo = 32'd4;
    @(negedge clk);
    check("b2b_done_pulse", done, 0);

    // reset mid-operation
    start_op(1'b0, 32'h12345678, 32'h9ABCDEF0);
    repeat (13) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_done", done, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    hold_hi = '0;
    hold_lo = '0;

    run_op("post_rst_3x5", 1'b0, 32'd3, 32'd5, 32'h00000000, 32'h0000000F);
    run_op("post_rst_m1sq", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
